// File: rtl/edge_tx_streamer.sv
// edge_tx_streamer: FIFO-buffered byte producer driving the UART tx_flag/tx_data strobe pair,
// pacing strobes with a fixed byte-frame timer because the transmitter reports no busy state.
module edge_tx_streamer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int GUARD_BITS = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              en,
  input  logic              clr_ovf,
  output logic              in_ready,
  output logic              tx_flag,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);
  localparam int BYTE_CYCLES = (CLK_FREQ / BAUD) * (10 + GUARD_BITS);
  localparam int CNT_W = BYTE_CYCLES > 2 ? $clog2(BYTE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic ovf_q, ovf_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic full, push, drop, pop, frame_end;
  always_comb begin
    full = level_q == (ADDR_W+1)'(FIFO_DEPTH);
    push = in_valid && !full;
    drop = in_valid && full;
    frame_end = cnt_q == CNT_W'(BYTE_CYCLES - 2);
    // The frame timer ends one cycle early so the next SEND lands exactly BYTE_CYCLES after the last.
    pop = en && level_q != '0 && (state_q == IDLE || (state_q == WAIT && frame_end));
    state_d = pop ? SEND : (state_q == SEND || (state_q == WAIT && !frame_end)) ? WAIT : IDLE;
    cnt_d = state_q == WAIT ? cnt_q + 1'b1 : '0;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
    ovf_d = drop || (ovf_q && !clr_ovf);
  end
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end
  always_ff @(posedge sclk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
  assign in_ready = !full;
  assign tx_flag  = state_q == SEND;
  assign busy     = state_q != IDLE;
  assign level    = level_q;
  assign tx_data  = tx_data_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_edge_tx_streamer.sv
// tb_edge_tx_streamer: directed scenarios checked each cycle against a queue/countdown model of the streamer.
module tb_edge_tx_streamer;
  localparam int BC = 110;
  localparam int DEPTH = 4;
  logic sclk = 0, rst_n = 0, in_valid = 0, en = 0, clr_ovf = 0;
  logic [7:0] in_data = 0;
  logic in_ready, tx_flag, busy, overflow;
  logic [7:0] tx_data;
  logic [2:0] level;
  int total = 0, bad = 0, cyc = 0, busy_cnt = 0;
  int s_cyc[$];
  logic [7:0] s_dat[$];
  logic [7:0] mq[$];
  int m_left = 0;
  logic m_flag = 0, m_ovf = 0;
  logic [7:0] m_data = 0;

  edge_tx_streamer #(.CLK_FREQ(1000), .BAUD(100), .GUARD_BITS(1), .FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .sclk(sclk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .en(en), .clr_ovf(clr_ovf),
    .in_ready(in_ready), .tx_flag(tx_flag), .tx_data(tx_data), .busy(busy), .level(level), .overflow(overflow)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc++;

  // Model: a byte queue plus a count of busy cycles left in the current frame.
  always @(posedge sclk or negedge rst_n) begin : model
    int n;
    bit pop, drop;
    if (!rst_n) begin
      mq.delete();
      m_left = 0;
      m_flag = 0;
      m_data = 0;
      m_ovf = 0;
    end else begin
      n = mq.size();
      pop = en && n > 0 && m_left <= 1;
      drop = in_valid && n == DEPTH;
      m_flag = pop;
      if (pop) begin
        m_data = mq.pop_front();
        m_left = BC;
      end else if (m_left > 0) m_left--;
      if (in_valid && !drop) mq.push_back(in_data);
      m_ovf = drop ? 1'b1 : clr_ovf ? 1'b0 : m_ovf;
    end
  end

  always @(negedge sclk) begin
    logic [14:0] act, exp;
    act = {tx_flag, tx_data, busy, level, overflow, in_ready};
    exp = {m_flag, m_data, m_left > 0, 3'(mq.size()), m_ovf, mq.size() != DEPTH};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cycle %0d outputs flag/data/busy/level/ovf/rdy got %b/%h/%b/%0d/%b/%b want %b/%h/%b/%0d/%b/%b",
               cyc, tx_flag, tx_data, busy, level, overflow, in_ready,
               exp[14], exp[13:6], exp[5], exp[4:2], exp[1], exp[0]);
    end
    if (tx_flag) begin
      s_cyc.push_back(cyc);
      s_dat.push_back(tx_data);
    end
    if (busy) busy_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sclk);
      #2;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 2000) begin
      step(1);
      k++;
    end
    chk({nm, " idle timeout"}, int'(busy), 0);
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1;
    in_data = d;
    step(1);
    in_valid = 0;
  endtask

  task automatic clear_log();
    s_cyc.delete();
    s_dat.delete();
  endtask

  initial begin
    int p, n;
    step(3);
    rst_n = 1;
    step(1);
    chk("reset tx_flag", tx_flag, 0);
    chk("reset level", level, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset tx_data", tx_data, 0);
    // single byte
    en = 1;
    clear_log();
    busy_cnt = 0;
    push(8'hA5);
    p = cyc;
    step(1);
    chk("single tx_flag", tx_flag, 1);
    chk("single tx_data", tx_data, 8'hA5);
    wait_idle("single");
    chk("single strobe cycle", s_cyc.size() > 0 ? s_cyc[0] : -1, p + 1);
    chk("single busy cycles", busy_cnt, 110);
    chk("single level", level, 0);
    // burst of three
    clear_log();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    step(2);
    wait_idle("burst");
    chk("burst count", s_dat.size(), 3);
    if (s_dat.size() == 3) begin
      chk("burst d0", s_dat[0], 8'h01);
      chk("burst d1", s_dat[1], 8'h02);
      chk("burst d2", s_dat[2], 8'h03);
      chk("burst gap0", s_cyc[1] - s_cyc[0], 110);
      chk("burst gap1", s_cyc[2] - s_cyc[1], 110);
    end
    chk("burst hold", tx_data, 8'h03);
    // overfill with en low
    en = 0;
    clear_log();
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    chk("full level", level, 4);
    chk("full in_ready", in_ready, 0);
    chk("full overflow", overflow, 1);
    en = 1;
    step(2);
    wait_idle("drain");
    chk("drain count", s_dat.size(), 4);
    if (s_dat.size() == 4) chk("drain last", s_dat[3], 8'h13);
    clr_ovf = 1;
    step(1);
    clr_ovf = 0;
    chk("clr overflow", overflow, 0);
    // drop while full and popping; clr_ovf racing a drop
    en = 0;
    clear_log();
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    en = 1;
    in_valid = 1;
    in_data = 8'h24;
    step(1);
    chk("pop+drop level", level, 3);
    chk("pop+drop overflow", overflow, 1);
    clr_ovf = 1;
    in_data = 8'h25;
    step(1);
    chk("refill level", level, 4);
    chk("clr no drop", overflow, 0);
    in_data = 8'h26;
    step(1);
    chk("clr with drop", overflow, 1);
    in_valid = 0;
    clr_ovf = 0;
    wait_idle("popdrop");
    chk("popdrop count", s_dat.size(), 5);
    if (s_dat.size() == 5) chk("popdrop last", s_dat[4], 8'h25);
    clr_ovf = 1;
    step(1);
    clr_ovf = 0;
    // en dropped mid-frame
    en = 0;
    clear_log();
    push(8'h30);
    push(8'h31);
    push(8'h32);
    en = 1;
    step(2);
    step(20);
    en = 0;
    wait_idle("endrop");
    step(5);
    chk("endrop strobes", s_dat.size(), 1);
    chk("endrop level", level, 2);
    en = 1;
    step(1);
    chk("reenable strobe", tx_flag, 1);
    chk("reenable data", tx_data, 8'h31);
    wait_idle("reenable");
    chk("reenable count", s_dat.size(), 3);
    // reset mid-frame
    en = 0;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    en = 1;
    step(1);
    step(50);
    rst_n = 0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst level", level, 0);
    chk("midrst tx_data", tx_data, 0);
    chk("midrst in_ready", in_ready, 1);
    n = s_dat.size();
    step(2);
    rst_n = 1;
    step(300);
    chk("no strobe after reset", s_dat.size(), n);
    push(8'h55);
    step(1);
    chk("post reset strobe", tx_flag, 1);
    chk("post reset data", tx_data, 8'h55);
    wait_idle("postrst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
